game_timer_ctrl: RTL
====================

Name: game_timer_ctrl

Overview:
- Producer end of the score/timer display path: generates the 6-bit seconds value (`number`) and `shoot_mode` that the two-digit 7-segment display driver renders.
- Implements a start/pause/resume countdown from START_VALUE seconds to 0, plus a shoot-mode selector.
- Button inputs are synchronised and edge-detected inside the block.
- Sits between the board push-buttons and the display driver.

Parameters:
- TICK_DIV, 50000000, clk cycles per one-second tick; must be ≥2.
- START_VALUE, 60, countdown reload value in seconds; legal range 1..63.
- MODE_COUNT, 4, number of shoot modes; `shoot_mode` wraps modulo this value; legal range 1..8.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- start_btn  in  1  raw start button, active-high, asynchronous to clk.
- pause_btn  in  1  raw pause/resume button, active-high, asynchronous to clk.
- mode_btn  in  1  raw shoot-mode button, active-high, asynchronous to clk.
- number  out  6  remaining seconds, binary, 0..START_VALUE.
- shoot_mode  out  3  current shoot mode, 0..MODE_COUNT-1.
- running  out  1  high while in RUN.
- time_up  out  1  high while in DONE.
- expired  out  1  one-cycle pulse on the RUN→DONE transition.

Behaviour:
- Reset (async, active-high) forces the following, regardless of clock:
  - state=IDLE; number=START_VALUE; shoot_mode=0; prescaler=0.
  - running=0; time_up=0; expired=0.
  - All synchroniser flops cleared.
- Button conditioning:
  - Each button passes through two sync flops (s1, s2) and one history flop (s3).
  - edge = s2 & ~s3.
  - An action takes effect at the 3rd rising clk edge after the raw input rises.
  - Holding a button produces exactly one edge.
- Prescaler: a counter of width clog2(TICK_DIV).
  - Increments only in RUN.
  - At prescaler==TICK_DIV-1 it wraps to 0 and a tick occurs in that same cycle.
- State IDLE:
  - number=START_VALUE.
  - start edge → RUN, prescaler=0.
  - pause edge ignored.
- State RUN:
  - running=1.
  - On a tick, number decrements by 1.
  - If the tick takes number from 1 to 0: → DONE, and expired=1 for exactly that cycle (expired is registered, high in the same cycle number first reads 0).
  - pause edge → PAUSE.
  - start edge ignored.
  - start and pause edges in the same cycle → PAUSE.
  - A pause edge in the same cycle as the final tick: the tick wins; → DONE with expired pulse.
- State PAUSE:
  - number and prescaler held.
  - pause edge or start edge → RUN, resuming from the held prescaler value (no restart of the partial second).
- State DONE:
  - number=0; time_up=1.
  - start edge → RUN with number=START_VALUE, prescaler=0.
  - pause edge ignored.
- shoot_mode:
  - A mode edge increments shoot_mode modulo MODE_COUNT, accepted only in IDLE and PAUSE.
  - Ignored in RUN and DONE.
  - Not altered by a start or reload.
- number never underflows below 0 and never exceeds START_VALUE.
- All outputs are registered; no combinational path from buttons to outputs.

Test Plan:
(All scenarios use TICK_DIV=4, START_VALUE=3, MODE_COUNT=4.)
1. Assert rst with no clock edge → immediately number=3, shoot_mode=0, running=0, time_up=0, expired=0.
2. Single start_btn pulse held 2 cycles:
   - running=1 at the 3rd clk edge.
   - number steps 3→2→1→0, one step every 4 clks.
   - expired=1 for exactly one cycle as number becomes 0; then time_up=1, running=0.
   - Further clocks keep number=0.
3. Pause during RUN when the prescaler holds 2:
   - number frozen across 20 clks.
   - After a pause edge to resume, the next decrement occurs 2 clks after re-entering RUN.
4. Mode edges (each held 2 cycles):
   - Five mode_btn edges in IDLE → shoot_mode sequence 1,2,3,0,1.
   - Then start, and two mode edges during RUN → shoot_mode stays 1.
5. Start and pause edges in the same cycle while in RUN → PAUSE, running=0; the later start edge → RUN.
6. Reset and restart:
   - Async rst asserted mid-RUN with number=1 → immediate IDLE, number=3, no expired pulse.
   - From DONE, a start edge → number=3, running=1, time_up=0.

Source files
------------

// File: rtl/game_timer_ctrl.sv
// -----------------------------------------------------------------------------
// game_timer_ctrl
//
// Countdown/shoot-mode controller that feeds the two-digit 7-segment display
// driver. It conditions three raw push-buttons and runs a start/pause/resume
// countdown from START_VALUE seconds down to 0. It also keeps a shoot-mode
// selector that the player steps through while the clock is not running.
//
// Parameters
//   TICK_DIV     clk cycles per one-second tick (>= 2)
//   START_VALUE  countdown reload value in seconds (1..63)
//   MODE_COUNT   number of shoot modes, shoot_mode wraps modulo this (1..8)
//
// Ports
//   clk         in   system clock, single domain
//   rst         in   asynchronous active-high reset
//   start_btn   in   raw start button, active-high, asynchronous to clk
//   pause_btn   in   raw pause/resume button, active-high, asynchronous to clk
//   mode_btn    in   raw shoot-mode button, active-high, asynchronous to clk
//   number      out  remaining seconds, binary, 0..START_VALUE
//   shoot_mode  out  current shoot mode, 0..MODE_COUNT-1
//   running     out  high while the countdown is running
//   time_up     out  high once the countdown has reached zero
//   expired     out  one-cycle pulse on the running -> time-up transition
//
// Every output comes straight from a flop, so there is no combinational path
// from the buttons to the display.
// -----------------------------------------------------------------------------
module game_timer_ctrl #(
  parameter int TICK_DIV    = 50000000,
  parameter int START_VALUE = 60,
  parameter int MODE_COUNT  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic       pause_btn,
  input  logic       mode_btn,
  output logic [5:0] number,
  output logic [2:0] shoot_mode,
  output logic       running,
  output logic       time_up,
  output logic       expired
);

  // ---------------------------------------------------------------------------
  // Constants
  // ---------------------------------------------------------------------------
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [5:0]    START_NUM  = 6'(START_VALUE);
  localparam logic [2:0]    MODE_LAST  = 3'(MODE_COUNT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ---------------------------------------------------------------------------
  // Button conditioning
  // Bit 0 and bit 1 form the two-flop synchroniser (s1, s2). Bit 2 (s3) holds
  // the previous synchronised value, so a held button yields a single edge.
  // The action therefore lands on the third rising clk edge after the press.
  // ---------------------------------------------------------------------------
  logic [2:0] start_sync_q;
  logic [2:0] pause_sync_q;
  logic [2:0] mode_sync_q;

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples the pre-edge value of its neighbours. The shift
  // registers below rely on this.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start_sync_q <= 3'b000;
      pause_sync_q <= 3'b000;
      mode_sync_q  <= 3'b000;
    end else begin
      start_sync_q <= {start_sync_q[1:0], start_btn};
      pause_sync_q <= {pause_sync_q[1:0], pause_btn};
      mode_sync_q  <= {mode_sync_q[1:0],  mode_btn};
    end
  end

  logic start_edge;
  logic pause_edge;
  logic mode_edge;

  assign start_edge = start_sync_q[1] & ~start_sync_q[2];
  assign pause_edge = pause_sync_q[1] & ~pause_sync_q[2];
  assign mode_edge  = mode_sync_q[1]  & ~mode_sync_q[2];

  // ---------------------------------------------------------------------------
  // Controller state
  // ---------------------------------------------------------------------------
  logic [1:0]    state_q,   state_d;
  logic [5:0]    number_q,  number_d;
  logic [PW-1:0] presc_q,   presc_d;
  logic [2:0]    mode_q,    mode_d;
  logic          running_q, time_up_q, expired_q;
  logic          expired_d;
  logic          tick;

  // The prescaler only advances in RUN, so its terminal count is a tick only
  // while running. The value is left untouched in PAUSE, so a resume continues
  // the partial second instead of restarting it.
  assign tick = (presc_q == PRESC_LAST);

  // NOTE: every variable driven here gets a default first. A missed branch
  // then holds the registered value instead of inferring a latch.
  always_comb begin
    state_d   = state_q;
    number_d  = number_q;
    presc_d   = presc_q;
    mode_d    = mode_q;
    expired_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        number_d = START_NUM;
        if (start_edge) begin
          state_d = ST_RUN;
          presc_d = '0;
        end
      end

      ST_RUN: begin
        presc_d = tick ? '0 : presc_q + PW'(1);
        if (tick && (number_q == 6'd1)) begin
          // The final tick wins over a pause edge in the same cycle.
          number_d  = 6'd0;
          state_d   = ST_DONE;
          expired_d = 1'b1;
        end else begin
          if (tick && (number_q != 6'd0)) begin
            number_d = number_q - 6'd1;
          end
          // A start edge is ignored here, even when it arrives with a pause.
          if (pause_edge) begin
            state_d = ST_PAUSE;
          end
        end
      end

      ST_PAUSE: begin
        if (start_edge || pause_edge) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        number_d = 6'd0;
        if (start_edge) begin
          state_d  = ST_RUN;
          number_d = START_NUM;
          presc_d  = '0;
        end
      end

      default: begin
        state_d  = ST_IDLE;
        number_d = START_NUM;
        presc_d  = '0;
      end
    endcase

    // Shoot mode can change only while the clock is stopped and not yet
    // expired. A start or a reload never touches it.
    if (mode_edge && ((state_q == ST_IDLE) || (state_q == ST_PAUSE))) begin
      mode_d = (mode_q >= MODE_LAST) ? 3'd0 : mode_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      number_q  <= START_NUM;
      presc_q   <= '0;
      mode_q    <= 3'd0;
      running_q <= 1'b0;
      time_up_q <= 1'b0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      number_q  <= number_d;
      presc_q   <= presc_d;
      mode_q    <= mode_d;
      // Status flags are registered from the next state. They therefore
      // change on the same edge as the state, and expired is high in the same
      // cycle that number first reads 0.
      running_q <= (state_d == ST_RUN);
      time_up_q <= (state_d == ST_DONE);
      expired_q <= expired_d;
    end
  end

  assign number     = number_q;
  assign shoot_mode = mode_q;
  assign running    = running_q;
  assign time_up    = time_up_q;
  assign expired    = expired_q;

endmodule
